// File: rtl/jtag_dr_pkg.sv
// Shared instruction codes and DR-length helpers for the JTAG data-register bank.
// Latency: none (declarations only); backpressure: n/a.
package jtag_dr_pkg;

  localparam int INSTR_W = 3;

  localparam logic [INSTR_W-1:0] I_BYPASS   = 3'd0;
  localparam logic [INSTR_W-1:0] I_IDCODE   = 3'd1;
  localparam logic [INSTR_W-1:0] I_SAMPLE   = 3'd2;
  localparam logic [INSTR_W-1:0] I_EXTEST   = 3'd3;
  localparam logic [INSTR_W-1:0] I_INTEST   = 3'd4;
  localparam logic [INSTR_W-1:0] I_USERCODE = 3'd5;
  localparam logic [INSTR_W-1:0] I_RUNBIST  = 3'd6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reserved code 7 falls through to the BYPASS length.
  function automatic int dr_len(input logic [INSTR_W-1:0] code, input int id_w,
                                input int bsr_w, input int uc_w, input int log_w);
    case (code)
      I_IDCODE:                     return id_w;
      I_SAMPLE, I_EXTEST, I_INTEST: return bsr_w;
      I_USERCODE:                   return uc_w;
      I_RUNBIST:                    return log_w;
      default:                      return 1;
    endcase
  endfunction

endpackage

// File: rtl/jtag_dr_bank_if.sv
// TAP-side and pad/core-side signal bundle for jtag_dr_bank.
// Latency: none (wires only); backpressure: n/a.
interface jtag_dr_bank_if
  import jtag_dr_pkg::*;
#(
  parameter int PIN_W  = 4,
  parameter int CORE_W = 4,
  parameter int UC_W   = 8,
  parameter int LOG_W  = 8
) ();

  logic               TDI;
  logic               CAPTUREDR;
  logic               SHIFTDR;
  logic               UPDATEDR;
  logic [INSTR_W-1:0] INSTR;
  logic [PIN_W-1:0]   PIN_IN;
  logic [CORE_W-1:0]  CORE_OUT;
  logic [LOG_W-1:0]   BIST_LOG;
  logic [PIN_W-1:0]   PIN_OUT;
  logic [CORE_W-1:0]  CORE_IN;
  logic [UC_W-1:0]    UC_OUT;
  logic               TDO;
  logic               LEN_ERR;

  modport master (
    output TDI, CAPTUREDR, SHIFTDR, UPDATEDR, INSTR, PIN_IN, CORE_OUT, BIST_LOG,
    input  PIN_OUT, CORE_IN, UC_OUT, TDO, LEN_ERR
  );

  modport slave (
    input  TDI, CAPTUREDR, SHIFTDR, UPDATEDR, INSTR, PIN_IN, CORE_OUT, BIST_LOG,
    output PIN_OUT, CORE_IN, UC_OUT, TDO, LEN_ERR
  );

endinterface

// File: rtl/jtag_dr_shift_chain.sv
// Shared DR shift register with variable-length TDI insertion; JTAG_DR_LENCHK_EN adds a shift-count check.
// Latency: capture/shift on posedge, TDO on following negedge; backpressure: none, TAP-paced.
module jtag_dr_shift_chain #(
  parameter int MAX_W = 32,
  parameter int PAR_W = 8,
  parameter int CW    = $clog2(MAX_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tdi,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic [CW-1:0]    len,
  input  logic [MAX_W-1:0] cap_data,
  output logic [PAR_W-1:0] par,
  output logic             tdo,
  output logic             upd_en,
  output logic             len_err
);

  logic [MAX_W-1:0] sr_q;
  logic [MAX_W-1:0] sr_dn;
  logic [MAX_W-1:0] mask;
  logic [MAX_W-1:0] shifted;
  logic             len_ok;

  assign sr_dn = sr_q >> 1;

  // Bits at or above the selected length hold their value while shifting.
  always_comb begin
    mask    = '0;
    shifted = sr_q;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
      if (i + 1 < int'(len))       shifted[i] = sr_dn[i];
      else if (i + 1 == int'(len)) shifted[i] = tdi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          sr_q <= '0;
    else if (capture) sr_q <= cap_data & mask;
    else if (shift)   sr_q <= shifted;
  end

  always_ff @(negedge clk) begin
    if (rst) tdo <= 1'b0;
    else     tdo <= sr_q[0];
  end

  assign par = sr_q[PAR_W-1:0];

`ifdef JTAG_DR_LENCHK_EN
  logic [CW-1:0] cnt;
  logic          err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (capture) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (shift) begin
      if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
    end else if (update && (cnt != len)) begin
      err <= 1'b1;
    end
  end

  assign len_ok  = (cnt == len);
  assign len_err = err;
`else
  assign len_ok  = 1'b1;
  assign len_err = 1'b0;
`endif

  assign upd_en = update & ~capture & ~shift & len_ok;

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG DR bank (BYPASS/IDCODE/BSR/USERCODE/RUNBIST) on one shift chain; JTAG_DR_LENCHK_EN enables LEN_ERR.
// Latency: capture/update on posedge TCK, TDO one negedge later; backpressure: none, TAP-paced.
module jtag_dr_bank
  import jtag_dr_pkg::*;
#(
  parameter int              PIN_W    = 4,
  parameter int              CORE_W   = 4,
  parameter int              ID_W     = 32,
  parameter logic [ID_W-1:0] ID_VALUE = 32'h0000_00A1,
  parameter int              UC_W     = 8,
  parameter logic [UC_W-1:0] UC_RESET = 8'h01,
  parameter int              LOG_W    = 8
) (
  input  logic          TCK,
  input  logic          RST,
  jtag_dr_bank_if.slave dr
);

  localparam int BSR_W = PIN_W + CORE_W;
  localparam int MAX_W = max2(max2(1, ID_W), max2(max2(BSR_W, UC_W), LOG_W));
  localparam int PAR_W = max2(BSR_W, UC_W);
  localparam int CW    = $clog2(MAX_W) + 1;

  logic [BSR_W-1:0] upd;
  logic [UC_W-1:0]  uc;
  logic [MAX_W-1:0] cap;
  logic [PAR_W-1:0] par;
  logic [CW-1:0]    len;
  logic             upd_en;
  logic             tdo;
  logic             len_err;

  assign len = CW'(dr_len(dr.INSTR, ID_W, BSR_W, UC_W, LOG_W));

  always_comb begin
    cap = '0;
    case (dr.INSTR)
      I_IDCODE:           cap[ID_W-1:0]  = ID_VALUE | ID_W'(1);
      I_SAMPLE, I_EXTEST: cap[BSR_W-1:0] = {dr.PIN_IN, dr.CORE_OUT};
      // INTEST observes the pad side from the update stage rather than the pins.
      I_INTEST:           cap[BSR_W-1:0] = {upd[BSR_W-1:CORE_W], dr.CORE_OUT};
      I_USERCODE:         cap[UC_W-1:0]  = uc;
      I_RUNBIST:          cap[LOG_W-1:0] = dr.BIST_LOG;
      default:            cap            = '0;
    endcase
  end

  jtag_dr_shift_chain #(
    .MAX_W (MAX_W),
    .PAR_W (PAR_W),
    .CW    (CW)
  ) u_chain (
    .clk      (TCK),
    .rst      (RST),
    .tdi      (dr.TDI),
    .capture  (dr.CAPTUREDR),
    .shift    (dr.SHIFTDR),
    .update   (dr.UPDATEDR),
    .len      (len),
    .cap_data (cap),
    .par      (par),
    .tdo      (tdo),
    .upd_en   (upd_en),
    .len_err  (len_err)
  );

  always_ff @(posedge TCK) begin
    if (RST) begin
      upd <= '0;
      uc  <= UC_RESET;
    end else if (upd_en) begin
      case (dr.INSTR)
        I_SAMPLE, I_EXTEST, I_INTEST: upd <= par[BSR_W-1:0];
        I_USERCODE:                   uc  <= par[UC_W-1:0];
        default:                      ;
      endcase
    end
  end

  assign dr.PIN_OUT = (dr.INSTR == I_EXTEST) ? upd[BSR_W-1:CORE_W] : '0;
  assign dr.CORE_IN = (dr.INSTR == I_INTEST) ? upd[CORE_W-1:0] : '0;
  assign dr.UC_OUT  = uc;
  assign dr.TDO     = tdo;
  assign dr.LEN_ERR = len_err;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Scoreboard bench for jtag_dr_bank: stimulus feeds a register-level model, a monitor checks TDO and parallel outputs.
module tb_jtag_dr_bank;

`ifdef JTAG_DR_LENCHK_EN
  localparam bit LENCHK = 1'b1;
`else
  localparam bit LENCHK = 1'b0;
`endif

  logic tck = 1'b0;
  logic rst;
  always #5 tck = ~tck;

  jtag_dr_bank_if #(.PIN_W(4), .CORE_W(4), .UC_W(8), .LOG_W(8)) dr ();

  jtag_dr_bank #(
    .PIN_W(4), .CORE_W(4), .ID_W(32), .ID_VALUE(32'h0000_00A1),
    .UC_W(8), .UC_RESET(8'h01), .LOG_W(8)
  ) dut (
    .TCK (tck),
    .RST (rst),
    .dr  (dr)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit tdo_q[$];

  logic [3:0] g_pin, g_core;
  logic [7:0] g_bist;

  // Reference state: DR contents as a number, plus the architectural registers.
  logic [63:0] m_sr;
  logic [7:0]  m_upd, m_uc;
  int          m_cnt;
  bit          m_lerr;
  logic [3:0]  exp_pin, exp_core;
  logic [7:0]  exp_uc;
  bit          exp_lerr;

  function automatic int dlen(input logic [2:0] c);
    case (c)
      3'd1:                         return 32;
      3'd2, 3'd3, 3'd4, 3'd5, 3'd6: return 8;
      default:                      return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit cp, input bit sh, input bit up,
                     input logic [2:0] ins, input bit tdi_v);
    int          l;
    logic [63:0] mask, cv;
    @(negedge tck);
    #1;
    rst = r;
    dr.CAPTUREDR = cp;
    dr.SHIFTDR   = sh;
    dr.UPDATEDR  = up;
    dr.INSTR     = ins;
    dr.TDI       = tdi_v;
    dr.PIN_IN    = g_pin;
    dr.CORE_OUT  = g_core;
    dr.BIST_LOG  = g_bist;
    l    = dlen(ins);
    mask = (64'd1 << l) - 64'd1;
    if (r) begin
      m_sr = '0; m_upd = '0; m_uc = 8'h01; m_cnt = 0; m_lerr = 1'b0;
    end else if (cp) begin
      case (ins)
        3'd1:       cv = 64'h0000_00A1 | 64'd1;
        3'd2, 3'd3: cv = 64'({g_pin, g_core});
        3'd4:       cv = 64'({m_upd[7:4], g_core});
        3'd5:       cv = 64'(m_uc);
        3'd6:       cv = 64'(g_bist);
        default:    cv = '0;
      endcase
      m_sr   = cv & mask;
      m_cnt  = 0;
      m_lerr = 1'b0;
    end else if (sh) begin
      tdo_q.push_back(m_sr[0]);
      m_sr = (m_sr & ~mask) | ((m_sr & mask) >> 1) | (64'(tdi_v) << (l - 1));
      if (m_cnt < 63) m_cnt++;
    end else if (up) begin
      if (!LENCHK || m_cnt == l) begin
        if (ins == 3'd2 || ins == 3'd3 || ins == 3'd4) m_upd = m_sr[7:0];
        else if (ins == 3'd5) m_uc = m_sr[7:0];
      end else begin
        m_lerr = 1'b1;
      end
    end
    exp_pin  = (ins == 3'd3) ? m_upd[7:4] : 4'h0;
    exp_core = (ins == 3'd4) ? m_upd[3:0] : 4'h0;
    exp_uc   = m_uc;
    exp_lerr = m_lerr;
  endtask

  task automatic capture(input logic [2:0] ins);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, ins, 1'b0);
  endtask

  task automatic shift_n(input logic [2:0] ins, input int n, input logic [63:0] data);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ins, data[i]);
  endtask

  task automatic update(input logic [2:0] ins);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, ins, 1'b0);
  endtask

  task automatic idle(input logic [2:0] ins);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ins, 1'b0);
  endtask

  // Monitor: pops one expected TDO bit per effective shift edge, checks parallel outputs every edge.
  initial begin
    logic s_rst, s_cap, s_sh;
    bit   e;
    forever begin
      @(posedge tck);
      s_rst = rst;
      s_cap = dr.CAPTUREDR;
      s_sh  = dr.SHIFTDR;
      #1;
      if (mon_en) begin
        if (!s_rst && !s_cap && s_sh) begin
          if (tdo_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL tdo_unexpected: got shift with empty scoreboard at %0t", $time);
          end else begin
            e = tdo_q.pop_front();
            check("tdo", 32'(dr.TDO), 32'(e));
          end
        end
        check("uc_out", 32'(dr.UC_OUT), 32'(exp_uc));
        check("pin_out", 32'(dr.PIN_OUT), 32'(exp_pin));
        check("core_in", 32'(dr.CORE_IN), 32'(exp_core));
        check("len_err", 32'(dr.LEN_ERR), 32'(exp_lerr));
        if (s_rst) begin
          @(negedge tck);
          #1;
          check("tdo_reset", 32'(dr.TDO), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ins;
    logic [63:0] d;
    int          n;
    rst = 1'b1;
    dr.TDI = 1'b0; dr.CAPTUREDR = 1'b0; dr.SHIFTDR = 1'b0; dr.UPDATEDR = 1'b0;
    dr.INSTR = 3'd0; dr.PIN_IN = '0; dr.CORE_OUT = '0; dr.BIST_LOG = '0;
    g_pin = 4'h0; g_core = 4'h0; g_bist = 8'h00;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    mon_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Reset mid-shift under USERCODE, then a fresh capture shifts out the reset value.
    capture(3'd5);
    shift_n(3'd5, 3, 64'h5);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
    capture(3'd5);
    shift_n(3'd5, 8, 64'h0);

    // IDCODE: 32 bits out, then the first TDI bit re-emerges.
    capture(3'd1);
    shift_n(3'd1, 33, 64'h1);

    // BYPASS one-bit delay.
    capture(3'd0);
    shift_n(3'd0, 4, 64'b1101);

    // PRELOAD via SAMPLE then drive pins via EXTEST; capture pins and core.
    capture(3'd2);
    shift_n(3'd2, 8, 64'hA5);
    update(3'd2);
    idle(3'd3);
    g_pin = 4'h3; g_core = 4'hC;
    capture(3'd3);
    shift_n(3'd3, 8, 64'h0);
    idle(3'd4);

    // USERCODE load, then a short shift before update.
    capture(3'd5);
    shift_n(3'd5, 8, 64'h5A);
    update(3'd5);
    capture(3'd5);
    shift_n(3'd5, 7, 64'h33);
    update(3'd5);
    idle(3'd5);
    capture(3'd5);
    shift_n(3'd5, 8, 64'h0);

    // RUNBIST: capture beats a simultaneous shift; update touches nothing.
    g_bist = 8'hC3;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1);
    shift_n(3'd6, 8, 64'h0);
    update(3'd6);
    idle(3'd3);

    // Randomized transactions with occasional wrong lengths and mid-shift instruction changes.
    repeat (150) begin
      ins    = 3'($urandom_range(0, 7));
      g_pin  = 4'($urandom);
      g_core = 4'($urandom);
      g_bist = 8'($urandom);
      capture(ins);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 34)) : dlen(ins);
      d = {32'($urandom), 32'($urandom)};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 19) == 0) ins = 3'($urandom_range(0, 7));
        g_pin = 4'($urandom);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, ins, d[i]);
      end
      update(ins);
      idle(ins);
    end

    // Unstructured control soup, including overlapping strobes and rare resets.
    repeat (400) begin
      g_pin  = 4'($urandom);
      g_core = 4'($urandom);
      g_bist = 8'($urandom);
      cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 5) == 0), 1'($urandom),
          1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 1'($urandom));
    end

    idle(3'd0);
    idle(3'd0);
    check("tdo_queue_drained", 32'(tdo_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_dr_bank.md
Name: jtag_dr_bank

Overview:
- Parametrised next-generation JTAG data-register bank behind the TAP controller.
- Holds BYPASS, IDCODE, boundary-scan (BSR, with an update/shadow stage), USERCODE and RUNBIST-log registers, all sharing one shift chain.
- Widths and reset values are generic.
- Drives TDO and the EXTEST pin outputs toward the pad ring and core.

Parameters:
- PIN_W, 4: number of pin boundary cells.
- CORE_W, 4: number of core-side boundary cells; BSR_W = PIN_W + CORE_W.
- ID_W, 32: IDCODE width.
- ID_VALUE, 32'h0000_00A1: IDCODE value; bit 0 is forced to 1 regardless of this value.
- UC_W, 8: USERCODE width.
- UC_RESET, 8'h01: USERCODE reset value.
- LOG_W, 8: BIST log width.
- MAX_W, derived: max(1, ID_W, BSR_W, UC_W, LOG_W); local only, not overridable.

Ports:
- TCK  in  1  TAP clock.
- RST  in  1  synchronous active-high reset.
- TDI  in  1  serial data in.
- CAPTUREDR  in  1  TAP in Capture-DR.
- SHIFTDR  in  1  TAP in Shift-DR.
- UPDATEDR  in  1  TAP in Update-DR.
- INSTR  in  3  decoded instruction code (see package).
- PIN_IN  in  PIN_W  pad input values.
- CORE_OUT  in  CORE_W  core output values.
- BIST_LOG  in  LOG_W  BIST result log.
- PIN_OUT  out  PIN_W  value driven to the pads.
- CORE_IN  out  CORE_W  value driven into the core.
- UC_OUT  out  UC_W  current USERCODE.
- TDO  out  1  serial data out.
- LEN_ERR  out  1  shift-length error flag (only with the optional feature; tied 0 otherwise).

Behaviour:
- Instruction codes: BYPASS=0, IDCODE=1, SAMPLE=2, EXTEST=3, INTEST=4, USERCODE=5, RUNBIST=6. Code 7 is reserved and acts as BYPASS.
- Selected DR length L:
  - BYPASS: 1
  - IDCODE: ID_W
  - SAMPLE, EXTEST, INTEST: BSR_W
  - USERCODE: UC_W
  - RUNBIST: LOG_W
- Shared shift register SR[MAX_W-1:0]. All posedge-TCK actions use priority CAPTUREDR > SHIFTDR > UPDATEDR.
- Capture, one cycle; SR bits >= L are cleared:
  - BYPASS: SR[0]=0.
  - IDCODE: ID_VALUE with bit 0 = 1.
  - SAMPLE/EXTEST: {PIN_IN, CORE_OUT}, with PIN_IN in the MSBs.
  - INTEST: {UPD_PIN, CORE_OUT}.
  - USERCODE: USERCODE register.
  - RUNBIST: BIST_LOG.
- Shift: SR[i] <= SR[i+1] for i < L-1, and SR[L-1] <= TDI. Bits >= L are held.
- Update (BSR shadow UPD[BSR_W-1:0] and USERCODE only):
  - SAMPLE, EXTEST, INTEST: UPD <= SR[BSR_W-1:0]. SAMPLE doubles as PRELOAD.
  - USERCODE: USERCODE <= SR[UC_W-1:0].
  - All other instructions: no update.
- Outputs:
  - PIN_OUT = UPD[BSR_W-1:CORE_W] when INSTR=EXTEST, else 0.
  - CORE_IN = UPD[CORE_W-1:0] when INSTR=INTEST, else 0.
  - UC_OUT = USERCODE.
- TDO is registered on negedge TCK from SR[0], so shifted data changes on falling edges. One-cycle latency: after capture, the first TDO bit is valid on the next falling edge.
- Reset (sampled on posedge; TDO cleared at the falling edge while RST=1):
  - SR=0, UPD=0, USERCODE=UC_RESET, TDO=0, LEN_ERR=0.
  - Reset takes priority over capture, shift and update, including mid-shift.
- An INSTR change during a shift takes effect next cycle with the new L; no realignment of SR.

Optional Feature:
- Macro: JTAG_DR_LENCHK_EN.
- Enabled:
  - A shift counter, width clog2(MAX_W)+1 and saturating, clears on capture and increments on each shift.
  - On update with count != L: the update is suppressed and LEN_ERR is set.
  - LEN_ERR is cleared by the next capture or by RST.
- Disabled: no counter, updates are unconditional, LEN_ERR tied 0.

Decomposition:
- Package jtag_dr_pkg holds:
  - instruction code localparams and the INSTR width;
  - a function returning L for a code;
  - a max() helper for MAX_W.
- One sub-module: jtag_dr_shift_chain, containing SR with variable-length insertion plus the optional counter/LEN_ERR. Capture data, update registers and muxes stay in the top.

Test Plan:
- RST high 2 cycles mid-shift (INSTR=5) -> UC_OUT=8'h01, TDO=0, SR cleared; a fresh capture then shifts out 1,0,0,0,0,0,0,0.
- INSTR=1, capture, 32 shifts with TDI=0 -> TDO stream LSB-first = 32'h000000A1; the 33rd bit out is TDI delayed by 32.
- INSTR=0, capture, shift TDI pattern 1,0,1,1 -> TDO = 0 followed by 1,0,1 (one-bit delay).
- INSTR=2, shift in 8'hA5, update; then INSTR=3 -> PIN_OUT=4'hA. Capture with PIN_IN=4'h3, CORE_OUT=4'hC shifts out 8'h3C LSB-first.
- INSTR=5, shift 8'h5A, update -> UC_OUT=8'h5A. With JTAG_DR_LENCHK_EN, shifting only 7 bits then updating -> UC_OUT unchanged and LEN_ERR=1; the next capture clears LEN_ERR.
- INSTR=6, BIST_LOG=8'hC3, capture with CAPTUREDR and SHIFTDR both high -> capture wins; 8 shifts yield 8'hC3; an update leaves UC_OUT and PIN_OUT unchanged.
